pcs_tx_scrambler: RTL and testbench
===================================

// Module: pcs_tx_scrambler
// PURPOSE
//  10GBASE-R PCS transmit scrambler: self-synchronising 1 + x^39 + x^58 scrambling of the 64-bit block payload
//  ahead of the TX gearbox. Companion to the RX descrambler; both use the same bit order and seed.
//  Sits between the 64b/66b encoder and the gearbox; the sync header passes through unscrambled, aligned to its payload.
// PARAMETERS
//  SEED        64'hFFFF_FFFF_FFFF_FFFF  scrambler history loaded on reset / !i_init_done (matches descrambler reset)
// PORTS
//  i_txc        in   1   TX PCS clock; all logic on posedge
//  i_reset      in   1   reset, synchronous, active-high
//  i_init_done  in   1   transceiver init complete; low acts as reset
//  i_tx_valid   in   1   gearbox accept strobe; low = pause, input not consumed, all state held
//  i_txd        in   64  encoder payload, bit 0 transmitted first
//  i_txh        in   2   encoder sync header, bit 0 transmitted first
//  i_test_en    in   1   select PRBS test pattern (only honoured with SCRAMBLER_TEST_PATTERN_EN)
//  o_txd        out  64  scrambled payload, registered
//  o_txh        out  2   sync header, registered, aligned with o_txd
//  o_tx_valid   out  1   registered copy of i_tx_valid (qualified by state)
// BEHAVIOUR
//  - History H[63:0] = last 64 scrambled bits, H[63] most recent. Per block, S = {new, H}:
//    new[i] = D[i] ^ S[25+i] ^ S[6+i], i=0..63; for i>=39 the S[25+i] term is a bit of the same block (unrolled chain).
//  - On a consumed block: o_txd <= new, H <= new, o_txh <= i_txh. Latency 1 cycle, data and header.
//  - States: INIT, RUN, TEST (TEST only with macro).
//    INIT: entered when i_reset | !i_init_done, from any state, same cycle priority over all else.
//          H <= SEED; o_txd <= 0; o_txh <= 0; o_tx_valid <= 0. Leave to RUN when !i_reset & i_init_done.
//    RUN:  i_tx_valid=1 -> consume block, o_tx_valid <= 1. i_tx_valid=0 -> H, o_txd, o_txh held, o_tx_valid <= 0.
//    TEST: as RUN but D forced to 64'h0, header forced to SYNC_DATA.
//  - Mode changes (RUN<->TEST) only on a cycle with i_tx_valid=1; block of that cycle already uses the new mode.
//  - Pause of any length is lossless: block after pause continues the scrambler sequence exactly.
//  - Reset mid-stream: outputs zero next cycle; first post-reset block scrambled from SEED.
//  - Header never alters H; control blocks scrambled identically to data blocks.
// CONFIGURATION
//  SCRAMBLER_TEST_PATTERN_EN defined: TEST state present, i_test_en honoured (IEEE 49.2.8 scrambled-zeros pattern).
//  Undefined: i_test_en port kept, ignored; FSM is INIT/RUN only; no forcing logic generated.
// STRUCTURE
//  - pcs_pkg: SYNC_DATA = 2'b10, SYNC_CTRL = 2'b01, SCRAMBLER_SEED default, scrambler_state_t enum {INIT, RUN, TEST}.
//  - Sub-module pcs_scramble_step: pure combinational (history[63:0], data[63:0]) -> scrambled[63:0];
//    top holds FSM, history register, output registers, test forcing.
// TESTING
//  1 Reset, init_done=1, i_txd=0, valid=1 -> first o_txd = 64'h03FF_FF80_0000_0000, o_txh = i_txh of that block.
//  2 1000 random blocks, random valid pauses -> loopback through RX descrambler returns i_txd exactly from block 0; vs C model.
//  3 valid low 3 cycles mid-stream -> o_txd/o_txh/H frozen, o_tx_valid=0; next block equals unpaused model output.
//  4 i_reset pulse mid-stream -> next cycle o_txd=0,o_tx_valid=0; zero data after -> 64'h03FF_FF80_0000_0000 again.
//  5 i_init_done drop for 2 cycles -> identical to case 4; no block consumed while low.
//  6 Macro on, i_test_en=1, i_txd=64'hDEAD_BEEF_0000_FFFF -> o_txh=2'b10, o_txd equals scrambled zeros; macro off -> ignored.

Source files
------------

// File: rtl/pcs_tx_scrambler_pkg.sv
// Purpose : shared constants and types for the 10GBASE-R PCS transmit scrambler.
// Contents: sync header codes, default scrambler seed, FSM state enum.
package pcs_tx_scrambler_pkg;

  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned HDR_W   = 2;

  localparam logic [HDR_W-1:0]   SYNC_DATA      = 2'b10;
  localparam logic [HDR_W-1:0]   SYNC_CTRL      = 2'b01;
  localparam logic [BLOCK_W-1:0] SCRAMBLER_SEED = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    TEST = 2'd2
  } scrambler_state_t;

endpackage

// File: rtl/pcs_tx_scrambler_if.sv
// Purpose : block bus between the 64b/66b encoder/gearbox side and the TX scrambler.
// Signals :
//   i_tx_valid  gearbox accept strobe (low = pause)
//   i_txd       64-bit encoder payload, bit 0 first on the line
//   i_txh       2-bit sync header, bit 0 first on the line
//   i_test_en   PRBS test pattern select
//   o_txd       scrambled payload
//   o_txh       sync header aligned with o_txd
//   o_tx_valid  output block valid
// Modports: master drives the i_* side, slave is the scrambler.
interface pcs_tx_scrambler_if;
  import pcs_tx_scrambler_pkg::*;

  logic               i_tx_valid;
  logic [BLOCK_W-1:0] i_txd;
  logic [HDR_W-1:0]   i_txh;
  logic               i_test_en;
  logic [BLOCK_W-1:0] o_txd;
  logic [HDR_W-1:0]   o_txh;
  logic               o_tx_valid;

  modport master (
    output i_tx_valid, i_txd, i_txh, i_test_en,
    input  o_txd, o_txh, o_tx_valid
  );

  modport slave (
    input  i_tx_valid, i_txd, i_txh, i_test_en,
    output o_txd, o_txh, o_tx_valid
  );

endinterface

// File: rtl/pcs_tx_scrambler_step.sv
// Purpose : one 64-bit step of the self-synchronising 1 + x^39 + x^58 scrambler.
// Ports   :
//   history_i    [63:0] last 64 scrambled bits, bit 63 most recent
//   data_i       [63:0] payload, bit 0 first on the line
//   scrambled_o  [63:0] scrambled payload (also the next history)
// Pure combinational.
module pcs_tx_scrambler_step
  import pcs_tx_scrambler_pkg::*;
(
  input  logic [BLOCK_W-1:0] history_i,
  input  logic [BLOCK_W-1:0] data_i,
  output logic [BLOCK_W-1:0] scrambled_o
);

  // s = {new, history}; new bits feed later bits of the same block once the
  // taps (distance 39 and 58) reach past the history boundary.
  logic [2*BLOCK_W-1:0] s;

  always_comb begin
    s = {{BLOCK_W{1'b0}}, history_i};
    for (int i = 0; i < 64; i++) begin
      s[7'(64 + i)] = data_i[6'(i)] ^ s[7'(25 + i)] ^ s[7'(6 + i)];
    end
    scrambled_o = s[2*BLOCK_W-1:BLOCK_W];
  end

endmodule

// File: rtl/pcs_tx_scrambler.sv
// Purpose : 10GBASE-R PCS transmit scrambler. Scrambles the 64-bit payload with
//           1 + x^39 + x^58, passes the sync header through aligned to its block.
// Ports   :
//   i_txc        TX PCS clock, posedge
//   i_reset      synchronous active-high reset
//   i_init_done  transceiver init complete; low behaves as reset
//   bus          pcs_tx_scrambler_if.slave (valid/data/header in, scrambled out)
// Parameters:
//   SEED         history loaded on reset / !i_init_done
// Build option:
//   SCRAMBLER_TEST_PATTERN_EN  adds the TEST state (scrambled-zeros pattern,
//                              header forced to SYNC_DATA) selected by i_test_en.
//                              Undefined: i_test_en is ignored.
module pcs_tx_scrambler
  import pcs_tx_scrambler_pkg::*;
#(
  parameter logic [63:0] SEED = SCRAMBLER_SEED
) (
  input  logic             i_txc,
  input  logic             i_reset,
  input  logic             i_init_done,
  pcs_tx_scrambler_if.slave bus
);

  scrambler_state_t   state_q, state_d;
  logic [BLOCK_W-1:0] hist_q, hist_d;
  logic [BLOCK_W-1:0] txd_q, txd_d;
  logic [HDR_W-1:0]   txh_q, txh_d;
  logic               vld_q, vld_d;

  logic               go_init;
  logic [BLOCK_W-1:0] blk_data;
  logic [HDR_W-1:0]   blk_hdr;
  logic [BLOCK_W-1:0] scr;

  assign go_init = i_reset | ~i_init_done;

  // State register
  always_ff @(posedge i_txc) begin
    state_q <= state_d;
  end

  // Next state; INIT wins over everything, mode changes only on accepted blocks
  always_comb begin
    state_d = state_q;
    if (go_init) begin
      state_d = INIT;
    end else begin
      case (state_q)
        INIT: begin
`ifdef SCRAMBLER_TEST_PATTERN_EN
          state_d = bus.i_test_en ? TEST : RUN;
`else
          state_d = RUN;
`endif
        end
        RUN: begin
`ifdef SCRAMBLER_TEST_PATTERN_EN
          if (bus.i_tx_valid && bus.i_test_en) state_d = TEST;
`endif
        end
`ifdef SCRAMBLER_TEST_PATTERN_EN
        TEST: begin
          if (bus.i_tx_valid && !bus.i_test_en) state_d = RUN;
        end
`endif
        default: state_d = INIT;
      endcase
    end
  end

  // Block source; in TEST the block of the switching cycle is already forced
`ifdef SCRAMBLER_TEST_PATTERN_EN
  always_comb begin
    blk_data = bus.i_txd;
    blk_hdr  = bus.i_txh;
    if (state_d == TEST) begin
      blk_data = '0;
      blk_hdr  = SYNC_DATA;
    end
  end
`else
  logic unused_test_en;
  assign unused_test_en = bus.i_test_en;
  assign blk_data       = bus.i_txd;
  assign blk_hdr        = bus.i_txh;
`endif

  pcs_tx_scrambler_step u_step (
    .history_i   (hist_q),
    .data_i      (blk_data),
    .scrambled_o (scr)
  );

  // Output / datapath next values; a pause holds history and output block
  always_comb begin
    hist_d = hist_q;
    txd_d  = txd_q;
    txh_d  = txh_q;
    vld_d  = 1'b0;
    if (go_init) begin
      hist_d = SEED;
      txd_d  = '0;
      txh_d  = '0;
    end else if (bus.i_tx_valid) begin
      hist_d = scr;
      txd_d  = scr;
      txh_d  = blk_hdr;
      vld_d  = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge i_txc) begin
    hist_q <= hist_d;
    txd_q  <= txd_d;
    txh_q  <= txh_d;
    vld_q  <= vld_d;
  end

  assign bus.o_txd      = txd_q;
  assign bus.o_txh      = txh_q;
  assign bus.o_tx_valid = vld_q;

endmodule

// File: tb/tb_pcs_tx_scrambler.sv
// Directed bench for pcs_tx_scrambler: serial reference scrambler and RX
// descrambler models, one task per scenario.
module tb_pcs_tx_scrambler;

  localparam logic [63:0] ZERO_FIRST = 64'h03FF_FF80_0000_0000;

  logic clk;
  logic rst;
  logic init_done;

  pcs_tx_scrambler_if bus ();

  pcs_tx_scrambler dut (
    .i_txc       (clk),
    .i_reset     (rst),
    .i_init_done (init_done),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Serial models: sr[0] = most recent line bit, taps at distance 39 and 58
  logic [57:0] m_sr;
  logic [57:0] r_sr;

  task automatic model_block(input logic [63:0] d, output logic [63:0] q);
    logic b;
    for (int i = 0; i < 64; i++) begin
      b     = d[i] ^ m_sr[38] ^ m_sr[57];
      q[i]  = b;
      m_sr  = {m_sr[56:0], b};
    end
  endtask

  task automatic descramble_block(input logic [63:0] q, output logic [63:0] d);
    for (int i = 0; i < 64; i++) begin
      d[i] = q[i] ^ r_sr[38] ^ r_sr[57];
      r_sr = {r_sr[56:0], q[i]};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_done = 1'b1;
    bus.i_tx_valid = 1'b1; bus.i_txd = 64'h1234_5678_9ABC_DEF0;
    bus.i_txh = 2'b01; bus.i_test_en = 1'b0;
    step(); step();
    checks++;
    if (bus.o_txd !== 64'h0) begin
      errors++; $display("FAIL reset_txd: got %h want 0", bus.o_txd);
    end
    checks++;
    if (bus.o_txh !== 2'b00) begin
      errors++; $display("FAIL reset_txh: got %b want 00", bus.o_txh);
    end
    checks++;
    if (bus.o_tx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", bus.o_tx_valid);
    end
  endtask

  task automatic test_first_block();
    logic [63:0] exp;
    m_sr = '1; r_sr = '1;
    rst = 1'b0;
    bus.i_txd = 64'h0; bus.i_txh = 2'b01; bus.i_tx_valid = 1'b1;
    model_block(64'h0, exp);
    step();
    checks++;
    if (bus.o_txd !== ZERO_FIRST) begin
      errors++; $display("FAIL first_txd: got %h want %h", bus.o_txd, ZERO_FIRST);
    end
    checks++;
    if (bus.o_txh !== 2'b01) begin
      errors++; $display("FAIL first_txh: got %b want 01", bus.o_txh);
    end
    checks++;
    if (bus.o_tx_valid !== 1'b1) begin
      errors++; $display("FAIL first_valid: got %b want 1", bus.o_tx_valid);
    end
    // Second zero block checks the history update
    bus.i_txh = 2'b10;
    model_block(64'h0, exp);
    step();
    checks++;
    if (bus.o_txd !== exp) begin
      errors++; $display("FAIL second_txd: got %h want %h", bus.o_txd, exp);
    end
  endtask

  task automatic test_stream();
    logic [63:0] d, exp, last, rx;
    logic [1:0]  h, last_h;
    m_sr = '1; r_sr = '1;
    rst = 1'b1; step(); rst = 1'b0;
    last = 64'h0; last_h = 2'b00;
    for (int i = 0; i < 40; i++) begin
      if (i % 7 == 3) begin
        bus.i_tx_valid = 1'b0;
        bus.i_txd = 64'hBAD0_BAD0_BAD0_BAD0; bus.i_txh = 2'b11;
        step();
        checks++;
        if (bus.o_tx_valid !== 1'b0 || bus.o_txd !== last || bus.o_txh !== last_h) begin
          errors++;
          $display("FAIL stream_pause[%0d]: got v=%b d=%h h=%b want v=0 d=%h h=%b",
                   i, bus.o_tx_valid, bus.o_txd, bus.o_txh, last, last_h);
        end
      end else begin
        d = 64'(64'h9E37_79B9_7F4A_7C15 * 64'(i + 1)) ^ {32'(i), 32'hA5A5_0000};
        h = (i % 2 == 0) ? 2'b10 : 2'b01;
        bus.i_tx_valid = 1'b1; bus.i_txd = d; bus.i_txh = h;
        model_block(d, exp);
        step();
        checks++;
        if (bus.o_txd !== exp || bus.o_txh !== h || bus.o_tx_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_blk[%0d]: got v=%b d=%h h=%b want v=1 d=%h h=%b",
                   i, bus.o_tx_valid, bus.o_txd, bus.o_txh, exp, h);
        end
        descramble_block(bus.o_txd, rx);
        checks++;
        if (rx !== d) begin
          errors++; $display("FAIL loopback[%0d]: got %h want %h", i, rx, d);
        end
        last = exp; last_h = h;
      end
    end
  endtask

  task automatic test_pause();
    logic [63:0] exp, last;
    bus.i_tx_valid = 1'b1; bus.i_txd = 64'h0F0F_1234_0000_8001; bus.i_txh = 2'b10;
    model_block(64'h0F0F_1234_0000_8001, last);
    step();
    bus.i_tx_valid = 1'b0; bus.i_txd = 64'hFFFF_0000_FFFF_0000; bus.i_txh = 2'b01;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.o_txd !== last || bus.o_txh !== 2'b10 || bus.o_tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL pause[%0d]: got v=%b d=%h h=%b want v=0 d=%h h=10",
                 c, bus.o_tx_valid, bus.o_txd, bus.o_txh, last);
      end
    end
    bus.i_tx_valid = 1'b1; bus.i_txd = 64'h8000_0000_0000_0001; bus.i_txh = 2'b01;
    model_block(64'h8000_0000_0000_0001, exp);
    step();
    checks++;
    if (bus.o_txd !== exp || bus.o_txh !== 2'b01 || bus.o_tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_pause: got v=%b d=%h h=%b want v=1 d=%h h=01",
               bus.o_tx_valid, bus.o_txd, bus.o_txh, exp);
    end
  endtask

  // Drops either i_reset or i_init_done for n cycles with live blocks offered
  task automatic test_reinit(input string nm, input bit use_rst, input int n);
    bus.i_tx_valid = 1'b1; bus.i_txd = 64'hCAFE_F00D_0BAD_BEEF; bus.i_txh = 2'b01;
    if (use_rst) rst = 1'b1; else init_done = 1'b0;
    for (int c = 0; c < n; c++) begin
      step();
      checks++;
      if (bus.o_txd !== 64'h0 || bus.o_txh !== 2'b00 || bus.o_tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_held[%0d]: got v=%b d=%h h=%b want v=0 d=0 h=00",
                 nm, c, bus.o_tx_valid, bus.o_txd, bus.o_txh);
      end
    end
    rst = 1'b0; init_done = 1'b1;
    bus.i_txd = 64'h0; bus.i_txh = 2'b10;
    step();
    checks++;
    if (bus.o_txd !== ZERO_FIRST || bus.o_txh !== 2'b10 || bus.o_tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_restart: got v=%b d=%h h=%b want v=1 d=%h h=10",
               nm, bus.o_tx_valid, bus.o_txd, bus.o_txh, ZERO_FIRST);
    end
  endtask

  task automatic test_test_pattern();
    logic [63:0] e1, e2;
    logic [1:0]  eh;
    m_sr = '1;
    rst = 1'b1; step(); rst = 1'b0;
    bus.i_test_en = 1'b1; bus.i_tx_valid = 1'b1;
    bus.i_txd = 64'hDEAD_BEEF_0000_FFFF; bus.i_txh = 2'b01;
`ifdef SCRAMBLER_TEST_PATTERN_EN
    model_block(64'h0, e1); model_block(64'h0, e2); eh = 2'b10;
`else
    model_block(64'hDEAD_BEEF_0000_FFFF, e1); model_block(64'hDEAD_BEEF_0000_FFFF, e2); eh = 2'b01;
`endif
    step();
    checks++;
    if (bus.o_txd !== e1 || bus.o_txh !== eh) begin
      errors++; $display("FAIL test_pat_1: got d=%h h=%b want d=%h h=%b",
                         bus.o_txd, bus.o_txh, e1, eh);
    end
    step();
    checks++;
    if (bus.o_txd !== e2 || bus.o_txh !== eh) begin
      errors++; $display("FAIL test_pat_2: got d=%h h=%b want d=%h h=%b",
                         bus.o_txd, bus.o_txh, e2, eh);
    end
    // Leaving test mode: this block already uses the real payload
    bus.i_test_en = 1'b0;
    model_block(64'hDEAD_BEEF_0000_FFFF, e1);
    step();
    checks++;
    if (bus.o_txd !== e1 || bus.o_txh !== 2'b01) begin
      errors++; $display("FAIL test_pat_exit: got d=%h h=%b want d=%h h=01",
                         bus.o_txd, bus.o_txh, e1);
    end
  endtask

  initial begin
    rst = 1'b1; init_done = 1'b0;
    bus.i_tx_valid = 1'b0; bus.i_txd = '0; bus.i_txh = '0; bus.i_test_en = 1'b0;
    test_reset();
    test_first_block();
    test_stream();
    test_pause();
    test_reinit("reset", 1'b1, 1);
    test_reinit("init_done", 1'b0, 2);
    test_test_pattern();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
